// File: rtl/dcache_pkg.sv
// Shared widths, line type and FSM state encoding for the direct-mapped write-back L1 data cache.
package dcache_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned NUM_LINES  = 32;
    localparam int unsigned LINE_BYTES = 32;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned OFF_W      = $clog2(LINE_BYTES);
    localparam int unsigned IDX_W      = $clog2(NUM_LINES);
    localparam int unsigned TAG_W      = ADDR_W - IDX_W - OFF_W;
    localparam int unsigned LINE_W     = 8 * LINE_BYTES;
    localparam int unsigned WORDS      = LINE_BYTES / 4;
    localparam int unsigned WSEL_W     = OFF_W - 2;

    typedef logic [WORDS-1:0][WORD_W-1:0] line_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_e;

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage: one asynchronous read port, one synchronous write port
// that either installs a full clean line or merges one word and marks the line dirty.
module dcache_sram
    import dcache_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [IDX_W-1:0]  idx_i,
    output logic [TAG_W-1:0]  rd_tag_o,
    output logic              rd_valid_o,
    output logic              rd_dirty_o,
    output line_t             rd_line_o,
    input  logic              wr_line_en_i,
    input  logic              wr_word_en_i,
    input  logic [TAG_W-1:0]  wr_tag_i,
    input  line_t             wr_line_i,
    input  logic [WSEL_W-1:0] wr_word_sel_i,
    input  logic [WORD_W-1:0] wr_word_i
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    line_t                data_q [NUM_LINES];

    assign rd_tag_o   = tag_q[idx_i];
    assign rd_valid_o = valid_q[idx_i];
    assign rd_dirty_o = dirty_q[idx_i];
    assign rd_line_o  = data_q[idx_i];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_line_en_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
        end else if (wr_word_en_i) begin
            dirty_q[idx_i] <= 1'b1;
        end
    end

    // Payload arrays carry no reset; valid gates every use of them.
    always_ff @(posedge clk_i) begin
        if (wr_line_en_i) begin
            tag_q[idx_i]  <= wr_tag_i;
            data_q[idx_i] <= wr_line_i;
        end else if (wr_word_en_i) begin
            data_q[idx_i][wr_word_sel_i] <= wr_word_i;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate L1 D-cache controller: same-cycle hits,
// pipeline stall on miss while the victim is written back and the line refilled.
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              p1_req_i,
    input  logic              p1_write_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [31:0]       p1_data_i,
    output logic [31:0]       p1_data_o,
    output logic              p1_stall_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
);

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [WSEL_W-1:0] req_word;
    logic              unused_addr_bits;

    assign req_tag          = p1_addr_i[ADDR_W-1:IDX_W+OFF_W];
    assign req_idx          = p1_addr_i[IDX_W+OFF_W-1:OFF_W];
    assign req_word         = p1_addr_i[OFF_W-1:2];
    assign unused_addr_bits = ^p1_addr_i[1:0];

    logic [TAG_W-1:0] rd_tag;
    logic             rd_valid;
    logic             rd_dirty;
    line_t            rd_line;
    logic             wr_line_en;
    logic             wr_word_en;
    logic             hit;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q;
    line_t             mem_data_q;
    logic [31:0]       hit_cnt_q, miss_cnt_q;
    logic              retry_q;

    dcache_sram u_sram (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .idx_i         (req_idx),
        .rd_tag_o      (rd_tag),
        .rd_valid_o    (rd_valid),
        .rd_dirty_o    (rd_dirty),
        .rd_line_o     (rd_line),
        .wr_line_en_i  (wr_line_en),
        .wr_word_en_i  (wr_word_en),
        .wr_tag_i      (req_tag),
        .wr_line_i     (mem_data_i),
        .wr_word_sel_i (req_word),
        .wr_word_i     (p1_data_i)
    );

    assign hit = p1_req_i & rd_valid & (rd_tag == req_tag);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (p1_req_i && !hit) state_d = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
            WRITEBACK: if (mem_ack_i) state_d = ALLOCATE;
            ALLOCATE:  if (mem_ack_i) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        wr_line_en   = 1'b0;
        wr_word_en   = 1'b0;
        p1_stall_o   = p1_req_i & ~((state_q == IDLE) & hit);
        p1_data_o    = hit ? rd_line[req_word] : 32'd0;
        case (state_q)
            IDLE:      wr_word_en = hit & p1_write_i;
            WRITEBACK: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
            end
            ALLOCATE:  begin
                mem_enable_o = 1'b1;
                wr_line_en   = mem_ack_i;
            end
            default:   ;
        endcase
    end

    // Memory address/line are latched so they stay stable through each request and hold in IDLE.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mem_addr_q <= '0;
            mem_data_q <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            retry_q    <= 1'b0;
        end else begin
            if (state_q == IDLE) begin
                retry_q <= 1'b0;
                if (hit && !retry_q) hit_cnt_q <= hit_cnt_q + 32'd1;
                if (p1_req_i && !hit) begin
                    miss_cnt_q <= miss_cnt_q + 32'd1;
                    mem_data_q <= rd_line;
                    mem_addr_q <= (rd_valid && rd_dirty) ? {rd_tag, req_idx, {OFF_W{1'b0}}}
                                                         : {req_tag, req_idx, {OFF_W{1'b0}}};
                end
            end
            if (state_q == WRITEBACK && mem_ack_i) mem_addr_q <= {req_tag, req_idx, {OFF_W{1'b0}}};
            if (state_q == ALLOCATE && mem_ack_i)  retry_q <= 1'b1;
        end
    end

    assign mem_addr_o = mem_addr_q;
    assign mem_data_o = mem_data_q;
    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl against a line-wide memory with a fixed 3-cycle ack latency.
module tb_dcache_ctrl;

    localparam int MEM_LAT = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         p1_req, p1_write;
    logic [31:0]  p1_addr, p1_wdata;
    logic [31:0]  p1_rdata;
    logic         p1_stall;
    logic         mem_enable, mem_write, mem_ack;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata;
    logic [31:0]  hit_cnt, miss_cnt;

    logic         ack_m = 1'b0;
    logic         ack_spur = 1'b0;
    int           lat_cnt = 0;
    int           wb_cnt = 0, fetch_cnt = 0;
    logic [31:0]  wb_addr = '0, fetch_addr = '0;
    logic [255:0] wb_data = '0;
    logic [255:0] mem_store [logic [31:0]];

    int n_checks = 0;
    int n_fail = 0;

    assign mem_ack = ack_m | ack_spur;

    always #5 clk = ~clk;

    dcache_ctrl dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .p1_req_i     (p1_req),
        .p1_write_i   (p1_write),
        .p1_addr_i    (p1_addr),
        .p1_data_i    (p1_wdata),
        .p1_data_o    (p1_rdata),
        .p1_stall_o   (p1_stall),
        .mem_enable_o (mem_enable),
        .mem_write_o  (mem_write),
        .mem_addr_o   (mem_addr),
        .mem_data_o   (mem_wdata),
        .mem_data_i   (mem_rdata),
        .mem_ack_i    (mem_ack),
        .hit_cnt_o    (hit_cnt),
        .miss_cnt_o   (miss_cnt)
    );

    // Untouched memory lines hold word w of line L = (L + 4w) ^ 0xA5A50000.
    function automatic logic [255:0] pat(input logic [31:0] a);
        logic [255:0] r;
        for (int w = 0; w < 8; w++) r[32*w +: 32] = (a + 32'(4*w)) ^ 32'hA5A5_0000;
        return r;
    endfunction

    always @(posedge clk) begin
        if (!mem_enable) begin
            lat_cnt <= 0;
            ack_m   <= 1'b0;
        end else if (ack_m) begin
            ack_m   <= 1'b0;
            lat_cnt <= 0;
            if (mem_write) begin
                mem_store[mem_addr] = mem_wdata;
                wb_cnt  = wb_cnt + 1;
                wb_addr = mem_addr;
                wb_data = mem_wdata;
            end else begin
                fetch_cnt  = fetch_cnt + 1;
                fetch_addr = mem_addr;
            end
        end else if (lat_cnt == MEM_LAT - 2) begin
            ack_m     <= 1'b1;
            mem_rdata <= mem_store.exists(mem_addr) ? mem_store[mem_addr] : pat(mem_addr);
        end else begin
            lat_cnt <= lat_cnt + 1;
        end
    end

    task automatic do_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                             output int stalls, output logic [31:0] rdata);
        @(negedge clk);
        p1_req   = 1'b1;
        p1_write = wr;
        p1_addr  = addr;
        p1_wdata = wdata;
        #1;
        stalls = 0;
        while (p1_stall && stalls < 100) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        rdata = p1_rdata;
        @(posedge clk);
        #1;
        p1_req   = 1'b0;
        p1_write = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; p1_req = 1'b0; p1_write = 1'b0; p1_addr = '0; p1_wdata = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (p1_stall !== 1'b0 || mem_enable !== 1'b0 || mem_write !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctrl: stall/en/wr=%b%b%b expected 000", p1_stall, mem_enable, mem_write);
        end
        n_checks++;
        if (mem_addr !== 32'h0 || p1_rdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_addr: mem_addr=%h p1_data=%h expected 0/0", mem_addr, p1_rdata);
        end
        n_checks++;
        if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
            n_fail++; $display("FAIL reset_cnt: hit=%0d miss=%0d expected 0/0", hit_cnt, miss_cnt);
        end
    endtask

    task automatic test_cold_load();
        int st; logic [31:0] rd;
        do_access(1'b0, 32'h0000_0040, 32'h0, st, rd);
        n_checks++;
        if (st !== 4) begin n_fail++; $display("FAIL cold_stall: got %0d cycles expected 4", st); end
        n_checks++;
        if (fetch_cnt !== 1 || fetch_addr !== 32'h40 || wb_cnt !== 0) begin
            n_fail++; $display("FAIL cold_mem: fetches=%0d addr=%h wbs=%0d expected 1/00000040/0", fetch_cnt, fetch_addr, wb_cnt);
        end
        n_checks++;
        if (rd !== 32'hA5A5_0040) begin n_fail++; $display("FAIL cold_data: got %h expected a5a50040", rd); end
        n_checks++;
        if (miss_cnt !== 32'd1 || hit_cnt !== 32'd0) begin
            n_fail++; $display("FAIL cold_cnt: hit=%0d miss=%0d expected 0/1", hit_cnt, miss_cnt);
        end
    endtask

    task automatic test_store_hit();
        int st1, st2; logic [31:0] rd;
        do_access(1'b1, 32'h0000_0044, 32'hDEAD_BEEF, st1, rd);
        do_access(1'b0, 32'h0000_0044, 32'h0, st2, rd);
        n_checks++;
        if (st1 !== 0 || st2 !== 0) begin n_fail++; $display("FAIL hit_stall: store=%0d load=%0d expected 0/0", st1, st2); end
        n_checks++;
        if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL hit_data: got %h expected deadbeef", rd); end
        n_checks++;
        if (dut.u_sram.dirty_q[2] !== 1'b1) begin n_fail++; $display("FAIL hit_dirty: dirty[2]=%b expected 1", dut.u_sram.dirty_q[2]); end
        n_checks++;
        if (hit_cnt !== 32'd2 || miss_cnt !== 32'd1) begin
            n_fail++; $display("FAIL hit_cnt: hit=%0d miss=%0d expected 2/1", hit_cnt, miss_cnt);
        end
    endtask

    task automatic test_dirty_evict();
        int st; logic [31:0] rd;
        do_access(1'b0, 32'h0000_0440, 32'h0, st, rd);
        n_checks++;
        if (st !== 7) begin n_fail++; $display("FAIL evict_stall: got %0d cycles expected 7", st); end
        n_checks++;
        if (wb_cnt !== 1 || wb_addr !== 32'h40) begin
            n_fail++; $display("FAIL evict_wb: wbs=%0d addr=%h expected 1/00000040", wb_cnt, wb_addr);
        end
        n_checks++;
        if (wb_data[63:32] !== 32'hDEAD_BEEF || wb_data[31:0] !== 32'hA5A5_0040) begin
            n_fail++; $display("FAIL evict_wbdata: w1=%h w0=%h expected deadbeef/a5a50040", wb_data[63:32], wb_data[31:0]);
        end
        n_checks++;
        if (fetch_cnt !== 2 || fetch_addr !== 32'h440) begin
            n_fail++; $display("FAIL evict_fetch: fetches=%0d addr=%h expected 2/00000440", fetch_cnt, fetch_addr);
        end
        n_checks++;
        if (rd !== 32'hA5A5_0440 || miss_cnt !== 32'd2) begin
            n_fail++; $display("FAIL evict_data: data=%h miss=%0d expected a5a50440/2", rd, miss_cnt);
        end
    endtask

    task automatic test_store_miss();
        int st; logic [31:0] rd, rd2;
        do_access(1'b1, 32'h0000_0088, 32'h1234_5678, st, rd);
        n_checks++;
        if (st !== 4) begin n_fail++; $display("FAIL smiss_stall: got %0d cycles expected 4", st); end
        n_checks++;
        if (wb_cnt !== 1 || fetch_cnt !== 3 || fetch_addr !== 32'h80) begin
            n_fail++; $display("FAIL smiss_mem: wbs=%0d fetches=%0d addr=%h expected 1/3/00000080", wb_cnt, fetch_cnt, fetch_addr);
        end
        do_access(1'b0, 32'h0000_0088, 32'h0, st, rd);
        do_access(1'b0, 32'h0000_008C, 32'h0, st, rd2);
        n_checks++;
        if (rd !== 32'h1234_5678 || rd2 !== 32'hA5A5_008C) begin
            n_fail++; $display("FAIL smiss_data: w2=%h w3=%h expected 12345678/a5a5008c", rd, rd2);
        end
        n_checks++;
        if (dut.u_sram.dirty_q[4] !== 1'b1 || miss_cnt !== 32'd3 || hit_cnt !== 32'd4) begin
            n_fail++; $display("FAIL smiss_state: dirty[4]=%b miss=%0d hit=%0d expected 1/3/4", dut.u_sram.dirty_q[4], miss_cnt, hit_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int st, f0; logic [31:0] rd;
        @(negedge clk);
        p1_req = 1'b1; p1_write = 1'b0; p1_addr = 32'h0000_0100;
        @(negedge clk);
        #1;
        n_checks++;
        if (mem_enable !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 32'h100) begin
            n_fail++; $display("FAIL rmid_alloc: en=%b wr=%b addr=%h expected 1/0/00000100", mem_enable, mem_write, mem_addr);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (mem_enable !== 1'b0 || mem_addr !== 32'h0) begin
            n_fail++; $display("FAIL rmid_drop: en=%b addr=%h expected 0/00000000", mem_enable, mem_addr);
        end
        n_checks++;
        if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
            n_fail++; $display("FAIL rmid_cnt: hit=%0d miss=%0d expected 0/0", hit_cnt, miss_cnt);
        end
        p1_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        f0 = fetch_cnt;
        do_access(1'b0, 32'h0000_0100, 32'h0, st, rd);
        n_checks++;
        if (st !== 4 || rd !== 32'hA5A5_0100 || fetch_cnt !== f0 + 1) begin
            n_fail++; $display("FAIL rmid_refetch: stalls=%0d data=%h fetches=%0d expected 4/a5a50100/%0d", st, rd, fetch_cnt, f0 + 1);
        end
        n_checks++;
        if (miss_cnt !== 32'd1 || hit_cnt !== 32'd0) begin
            n_fail++; $display("FAIL rmid_after: hit=%0d miss=%0d expected 0/1", hit_cnt, miss_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] h0, m0;
        int f0, w0, stall_seen;
        h0 = hit_cnt; m0 = miss_cnt; f0 = fetch_cnt; w0 = wb_cnt;
        @(negedge clk);
        ack_spur = 1'b1;
        @(negedge clk);
        ack_spur = 1'b0;
        #1;
        n_checks++;
        if (mem_enable !== 1'b0 || p1_stall !== 1'b0 || miss_cnt !== m0 || fetch_cnt !== f0 || wb_cnt !== w0) begin
            n_fail++; $display("FAIL spur_ack: en=%b stall=%b miss=%0d fetches=%0d expected 0/0/%0d/%0d", mem_enable, p1_stall, miss_cnt, fetch_cnt, m0, f0);
        end
        stall_seen = 0;
        for (int w = 0; w < 8; w++) begin
            @(negedge clk);
            p1_req = 1'b1; p1_write = 1'b0; p1_addr = 32'h0000_0100 + 32'(4*w);
            #1;
            if (p1_stall) stall_seen++;
            n_checks++;
            if (p1_rdata !== (32'hA5A5_0100 + 32'(4*w))) begin
                n_fail++; $display("FAIL b2b_data: word %0d got %h expected %h", w, p1_rdata, 32'hA5A5_0100 + 32'(4*w));
            end
        end
        @(negedge clk);
        p1_req = 1'b0;
        #1;
        n_checks++;
        if (stall_seen !== 0) begin n_fail++; $display("FAIL b2b_stall: stalled %0d cycles expected 0", stall_seen); end
        n_checks++;
        if (hit_cnt !== h0 + 32'd8 || miss_cnt !== m0) begin
            n_fail++; $display("FAIL b2b_cnt: hit=%0d miss=%0d expected %0d/%0d", hit_cnt, miss_cnt, h0 + 32'd8, m0);
        end
    endtask

    initial begin
        test_reset();
        test_cold_load();
        test_store_hit();
        test_dirty_evict();
        test_store_miss();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache.
- Sits between the CPU MEM stage (load/store address from EX/MEM ALU result, store data from the forwarded RT path) and a slow line-wide data memory.
- Hits complete in the same cycle. Misses stall the whole pipeline through p1_stall_o until the line is refilled.
- Carries hit and miss counters for performance reporting.

Parameters:
- ADDR_W, 32, byte-address width.
- NUM_LINES, 32, number of cache lines (power of two).
- LINE_BYTES, 32, bytes per line (power of two, ≥ 8).
- Derived widths:
  - OFF_W = log2(LINE_BYTES)
  - IDX_W = log2(NUM_LINES)
  - TAG_W = ADDR_W - IDX_W - OFF_W
  - LINE_W = 8 * LINE_BYTES

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- p1_req_i  in  1  CPU access valid (MemRead or MemWrite).
- p1_write_i  in  1  1 = store, 0 = load.
- p1_addr_i  in  ADDR_W  byte address; bits [1:0] ignored.
- p1_data_i  in  32  store data.
- p1_data_o  out  32  load data.
- p1_stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- mem_enable_o  out  1  memory request valid.
- mem_write_o  out  1  1 = line write-back, 0 = line fetch.
- mem_addr_o  out  ADDR_W  line-aligned address (offset bits zero).
- mem_data_o  out  LINE_W  write-back line.
- mem_data_i  in  LINE_W  fetched line.
- mem_ack_i  in  1  one-cycle pulse; request complete.
- hit_cnt_o  out  32  hits counted.
- miss_cnt_o  out  32  misses counted.

Behaviour:
- Address split:
  - tag = addr[ADDR_W-1 : IDX_W+OFF_W]
  - idx = addr[IDX_W+OFF_W-1 : OFF_W]
  - word = addr[OFF_W-1 : 2]
- hit = p1_req_i & valid[idx] & (tag_arr[idx] == tag). Evaluated combinationally.
- Reset (asynchronous):
  - state = IDLE; all valid and dirty bits = 0.
  - Counters = 0; retry flag = 0.
  - mem_enable_o = 0, mem_write_o = 0, mem_addr_o = 0, p1_stall_o = 0.
  - Data and tag arrays are not reset.
- Reset mid-transaction: the memory request is dropped (mem_enable_o falls asynchronously) and the cache returns to cold state.
- p1_data_o:
  - On a hit, the selected word of line idx, combinationally.
  - Otherwise 0.
- p1_stall_o = p1_req_i & ~(state == IDLE & hit). Combinational, so a miss stalls in the same cycle it is presented.
- States:
  - IDLE
    - Hit load: no state change.
    - Hit store: at the clock edge, write the word and set dirty[idx] = 1.
    - Miss with dirty victim: go to WRITEBACK.
    - Miss with clean or invalid victim: go to ALLOCATE.
    - miss_cnt increments on the miss-detect edge.
  - WRITEBACK
    - mem_enable_o = 1, mem_write_o = 1.
    - mem_addr_o = {tag_arr[idx], idx, 0}; mem_data_o = data_arr[idx].
    - Hold these until mem_ack_i, then go to ALLOCATE.
  - ALLOCATE
    - mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {tag, idx, 0}.
    - On mem_ack_i: install mem_data_i, set tag, valid = 1, dirty = 0, set retry = 1, go to IDLE.
  - Back in IDLE after a refill, the held request hits. A store merges its word and sets dirty in that cycle; a load returns data with stall low.
- Worst-case miss latency is writeback latency + fetch latency + 1 cycle.
- hit_cnt increments on an IDLE hit edge only when retry = 0, so refill completions are not counted as hits. retry clears on any IDLE edge.
- Counters wrap modulo 2^32.
- mem_ack_i is ignored in IDLE.
- The CPU holds p1_* stable while p1_stall_o = 1. If p1_req_i drops during a miss, the refill still completes and the line is installed; no data is returned.
- In IDLE, mem_enable_o = 0 and mem_addr_o/mem_data_o hold their last values.

Decomposition:
- dcache_pkg: state enum (IDLE, WRITEBACK, ALLOCATE) and the derived width constants OFF_W, IDX_W, TAG_W, LINE_W.
- Sub-module dcache_sram:
  - Holds the tag, valid, dirty and data arrays.
  - One asynchronous read port.
  - One synchronous write port: full-line install, or word merge with dirty set.
  - Valid and dirty clear on rst_n_i.
- dcache_ctrl contains the FSM, address split, stall logic and counters.

Test Plan:
- Cold load at 0x0000_0040 with 3-cycle memory latency:
  - Stall for 4 cycles; one fetch at mem_addr 0x40.
  - p1_data_o equals the word fetched from memory.
  - miss_cnt = 1, hit_cnt = 0.
- Store 0xDEADBEEF to 0x44, then load 0x44:
  - Both complete with no stall; load returns 0xDEADBEEF.
  - dirty[2] = 1, hit_cnt = 2.
- Load 0x0000_0440 (same index 2, different tag) after the dirty store:
  - Write-back at mem_addr 0x40 whose line word 1 = 0xDEADBEEF.
  - Then a fetch at mem_addr 0x440.
  - miss_cnt increments by 1.
- Store miss to a clean index:
  - Single fetch, no write-back.
  - Merged word reads back; line marked dirty.
- Assert rst_n_i low during the ALLOCATE wait:
  - mem_enable_o drops immediately.
  - After release, the same address misses again and both counters are 0.
- Spurious mem_ack_i pulse in IDLE plus back-to-back hits on 8 words of one line:
  - No state change.
  - hit_cnt increases by 8; p1_stall_o never asserts.
